// File: rtl/frodo_mac_array.sv
// frodo_mac_array: two-stage LANES-wide MAC/ADD array with first/last accumulation runs, mod 2^LOGQ.
module frodo_mac_array #(
    parameter int LANES = 4,
    parameter int AW    = 8,
    parameter int BW    = 16,
    parameter int LOGQ  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [1:0]            op,
    input  logic [LANES*AW-1:0]   a,
    input  logic [LANES*BW-1:0]   b,
    input  logic [LANES*BW-1:0]   c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*BW-1:0]   out_data,
    output logic                  seq_err,
    output logic                  busy
);
    localparam logic [BW-1:0] MASK = {BW{1'b1}} >> (BW - LOGQ);

    logic                adv, s2_fire;
    logic                s1_valid, s1_first, s1_last, run_open;
    logic [LANES*BW-1:0] term, s1_p, s1_c, acc, sum;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign s2_fire  = adv & s1_valid;
    assign busy     = s1_valid | run_open | out_valid;

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            logic [BW-1:0] a_ext, prod, base;
            assign a_ext = BW'($signed(a[i*AW +: AW]));
            assign prod  = a_ext * b[i*BW +: BW];
            assign base  = op[1] ? b[i*BW +: BW] : prod;
            assign term[i*BW +: BW] = op[0] ? -base : base;
            assign sum[i*BW +: BW]  = ((s1_first ? s1_c[i*BW +: BW] : acc[i*BW +: BW]) + s1_p[i*BW +: BW]) & MASK;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_p     <= '0;
            s1_c     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_p     <= term;
            s1_c     <= c;
        end
    end

    // A framing error is a first beat while a run is open, or a non-first beat while none is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            run_open  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            if (s2_fire) acc <= sum;
            if (s2_fire & s1_last) begin
                out_data  <= sum;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (s2_fire) run_open <= ~s1_last & (s1_first | run_open);
            if (s2_fire & (s1_first == run_open)) seq_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frodo_mac_array.sv
// tb_frodo_mac_array: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_frodo_mac_array;
    localparam int LANES = 4, AW = 8, BW = 16, LOGQ = 15, W = LANES*BW, WA = LANES*AW;

    logic          clk = 0, rstn = 0;
    logic          in_valid = 0, in_first = 0, in_last = 0, out_ready = 1;
    logic [1:0]    op = 0;
    logic [WA-1:0] a = 0;
    logic [W-1:0]  b = 0, c = 0;
    logic          in_ready, out_valid, seq_err, busy;
    logic [W-1:0]  out_data;

    int errors = 0, checks = 0;
    logic [W-1:0] exp_q[$];

    frodo_mac_array #(.LANES(LANES), .AW(AW), .BW(BW), .LOGQ(LOGQ)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .op(op), .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .seq_err(seq_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rep(input logic [BW-1:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [WA-1:0] repa(input logic [AW-1:0] v);
        return {LANES{v}};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic send(input logic f, input logic l, input logic [1:0] o,
                        input logic [WA-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv);
        int n = 0;
        in_valid = 1; in_first = f; in_last = l; op = o; a = av; b = bv; c = cv;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending got %0d want 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h want none", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no end want finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rstn = 1;

        // single shot with latency check
        exp_q.push_back(rep(16'd305));
        send(1, 1, 2'b00, repa(8'd3), rep(16'd100), rep(16'd5));
        check("lat_edge_t", out_valid, 0);
        @(posedge clk);
        #1 check("lat_edge_t1", out_valid, 1);
        drain();
        check("single_seq_err", seq_err, 0);

        // lane-distinct single shot
        exp_q.push_back({16'd403, 16'd302, 16'd201, 16'd100});
        send(1, 1, 2'b00, {8'd4, 8'd3, 8'd2, 8'd1}, rep(16'd100), {16'd3, 16'd2, 16'd1, 16'd0});
        // MSUB with negative a and wrap
        exp_q.push_back(rep(16'h0010));
        send(1, 1, 2'b01, repa(8'hFE), rep(16'h4000), rep(16'h0010));
        drain();

        // three-beat run with a bubble
        exp_q.push_back(rep(16'd141));
        send(1, 0, 2'b00, repa(8'd1), rep(16'd10), rep(16'd1));
        send(0, 0, 2'b00, repa(8'd2), rep(16'd20), rep(16'd0));
        @(posedge clk);
        #1;
        send(0, 1, 2'b00, repa(8'd3), rep(16'd30), rep(16'd0));
        drain();
        check("run_seq_err", seq_err, 0);

        // ADD / SUB wrap
        exp_q.push_back(rep(16'h0000));
        send(1, 1, 2'b10, repa(8'd0), rep(16'h7FFF), rep(16'd1));
        exp_q.push_back(rep(16'h7FFF));
        send(1, 1, 2'b11, repa(8'd0), rep(16'd2), rep(16'd1));
        drain();

        // backpressure
        out_ready = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    exp_q.push_back(rep(16'(k*10 + 1)));
                    send(1, 1, 2'b10, repa(8'd0), rep(16'd1), rep(16'(k*10)));
                end
            end
            begin
                int n = 0;
                logic [W-1:0] held;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                held = out_data;
                check("bp_first_valid", out_valid, 1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_hold", out_data, held);
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();

        // framing: non-first beat right after reset
        rstn = 0;
        @(posedge clk);
        #1 rstn = 1;
        exp_q.push_back(rep(16'd7));
        send(0, 1, 2'b10, repa(8'd0), rep(16'd7), rep(16'd99));
        drain();
        check("frame_seq_err", seq_err, 1);
        exp_q.push_back(rep(16'd10));
        send(1, 1, 2'b00, repa(8'd2), rep(16'd3), rep(16'd4));
        exp_q.push_back(rep(16'd21));
        send(1, 0, 2'b10, repa(8'd0), rep(16'd5), rep(16'd100));
        send(1, 1, 2'b10, repa(8'd0), rep(16'd1), rep(16'd20));
        drain();
        check("frame_seq_sticky", seq_err, 1);

        // reset mid-run
        send(1, 0, 2'b00, repa(8'd1), rep(16'd1), rep(16'd0));
        send(0, 0, 2'b00, repa(8'd1), rep(16'd1), rep(16'd0));
        check("mid_busy", busy, 1);
        rstn = 0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_seq_err", seq_err, 0);
        check("mid_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        exp_q.push_back(rep(16'd5));
        send(1, 1, 2'b00, repa(8'hFF), rep(16'd5), rep(16'd10));
        drain();
        check("post_rst_seq_err", seq_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
